// File: rtl/reg_hazard_scoreboard.sv
// Register write-pending scoreboard: blocks issue on RAW/WAW hazards and counts stalled cycles.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback resolve a hazard immediately.
module reg_hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  logic [REG_ADDR_W-1:0]  issue_rs1,
    input  logic [REG_ADDR_W-1:0]  issue_rs2,
    input  logic [REG_ADDR_W-1:0]  issue_rd,
    input  logic                   issue_rd_we,
    output logic                   issue_ready,
    input  logic                   wb_valid,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic                   flush,
    output logic [NUM_REGS-1:0]    pending_mask,
    output logic                   wb_err,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int DEPTH = 1 << REG_ADDR_W;

    // Index space padded to the full address range so out-of-range indices read as idle x0
    logic [DEPTH-1:0]    pend_ext;
    logic [DEPTH-1:0]    in_range;
    logic [DEPTH-1:0]    bypass;
    logic [DEPTH-1:0]    eff_pend;
    logic [DEPTH-1:0]    ext_next;
    logic [NUM_REGS-1:0] mask_next;
    logic                hazard;
    logic                accept;
    logic                wb_err_next;

    always_comb begin
        pend_ext                 = '0;
        pend_ext[NUM_REGS-1:0]   = pending_mask;
        in_range                 = '0;
        in_range[NUM_REGS-1:1]   = '1;
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    always_comb begin
        bypass = '0;
        if (wb_valid && !flush) bypass[wb_rd] = 1'b1;
    end
`else
    always_comb bypass = '0;
`endif

    always_comb begin
        eff_pend    = pend_ext & ~bypass;
        hazard      = eff_pend[issue_rs1] | eff_pend[issue_rs2] | (issue_rd_we & eff_pend[issue_rd]);
        issue_ready = !hazard && !flush;
        accept      = issue_valid && issue_ready;
    end

    // Clear is applied before set so an issue to rd wins over a writeback of rd
    always_comb begin
        ext_next    = pend_ext;
        wb_err_next = 1'b0;
        if (flush) begin
            ext_next = '0;
        end else begin
            if (wb_valid) begin
                ext_next[wb_rd] = 1'b0;
                wb_err_next     = in_range[wb_rd] && !pend_ext[wb_rd];
            end
            if (accept && issue_rd_we) ext_next[issue_rd] = 1'b1;
        end
        ext_next[0] = 1'b0;
        mask_next   = ext_next[NUM_REGS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_mask <= '0;
            wb_err       <= 1'b0;
            stall_count  <= '0;
        end else begin
            pending_mask <= mask_next;
            wb_err       <= wb_err_next;
            if (issue_valid && !issue_ready && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Randomised and directed bench for reg_hazard_scoreboard against a behavioural pending-set model.
module tb_reg_hazard_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_rd_we, wb_valid, flush;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
    logic        ready16, ready4, err16, err4;
    logic [31:0] mask16, mask4;
    logic [15:0] stall16;
    logic [3:0]  stall4;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pend;
    bit          m_err;
    int          m_stall16, m_stall4;
    bit          seen_ready;

    reg_hazard_scoreboard #(.NUM_REGS(32), .REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .issue_ready(ready16), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .pending_mask(mask16), .wb_err(err16), .stall_count(stall16));

    reg_hazard_scoreboard #(.NUM_REGS(32), .REG_ADDR_W(5), .STALL_CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .issue_ready(ready4), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .pending_mask(mask4), .wb_err(err4), .stall_count(stall4));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A register blocks issue if a write is outstanding and not being written back right now (bypass)
    function automatic bit blocks(input logic [4:0] i);
        if (i == 0 || !m_pend[i]) return 1'b0;
        if (BYPASS && wb_valid && !flush && wb_rd == i) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_ready();
        if (flush) return 1'b0;
        return !(blocks(issue_rs1) || blocks(issue_rs2) || (issue_rd_we && blocks(issue_rd)));
    endfunction

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_rd_we = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    // Called at posedge+1 with inputs driven; compares at negedge then advances the model
    task automatic cycle();
        logic [31:0] n;
        bit          nerr, r;
        @(negedge clk);
        r = model_ready();
        seen_ready = ready16;
        check("issue_ready", ready16, r);
        check("issue_ready_w4", ready4, r);
        check("pending_mask", mask16, m_pend);
        check("pending_mask_w4", mask4, m_pend);
        check("wb_err", err16, m_err);
        check("stall_count", stall16, m_stall16);
        check("stall_count_w4", stall4, m_stall4);
        n = m_pend;
        nerr = 0;
        if (!flush) begin
            if (wb_valid && wb_rd != 0) begin
                if (m_pend[wb_rd]) n[wb_rd] = 1'b0;
                else nerr = 1'b1;
            end
            if (issue_valid && r && issue_rd_we && issue_rd != 0) n[issue_rd] = 1'b1;
        end else begin
            n = '0;
        end
        if (issue_valid && !r) begin
            if (m_stall16 < 65535) m_stall16++;
            if (m_stall4 < 15) m_stall4++;
        end
        @(posedge clk);
        #1;
        m_pend = n;
        m_err  = nerr;
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        check("rst_mask", mask16, 0);
        check("rst_mask_w4", mask4, 0);
        check("rst_stall", stall16, 0);
        check("rst_stall_w4", stall4, 0);
        check("rst_err", err16, 0);
        m_pend = '0; m_err = 0; m_stall16 = 0; m_stall4 = 0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic issue(input int rs1, input int rs2, input int rd, input bit we);
        idle();
        issue_valid = 1; issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2); issue_rd = 5'(rd); issue_rd_we = we;
    endtask

    initial begin
        idle();
        rst_n = 0;
        m_pend = '0; m_err = 0; m_stall16 = 0; m_stall4 = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Basic RAW stall and release
        issue(0, 0, 5, 1); cycle();
        check("lit_set5", mask16, 32'h20);
        issue(5, 0, 0, 0); cycle();
        check("lit_stall_ready", seen_ready, 0);
        check("lit_stall1", stall16, 1);
        idle(); wb_valid = 1; wb_rd = 5; cycle();
        check("lit_wb5_mask", mask16, 0);
        issue(5, 0, 0, 0); cycle();
        check("lit_after_wb_ready", seen_ready, 1);

        // x0 never becomes pending
        issue(0, 0, 0, 1); cycle();
        issue(0, 0, 0, 0); cycle();
        check("lit_x0_ready", seen_ready, 1);
        check("lit_x0_mask", mask16, 0);

        // Writeback in the same cycle as a dependent issue
        issue(0, 0, 7, 1); cycle();
        issue(0, 7, 0, 0); wb_valid = 1; wb_rd = 7; cycle();
        check("lit_bypass_ready", seen_ready, BYPASS);
        check("lit_bypass_mask", mask16, 0);

        // Flush discards everything
        issue(0, 0, 3, 1); cycle();
        issue(0, 0, 9, 1); cycle();
        check("lit_pend_3_9", mask16, 32'h208);
        issue(0, 0, 0, 0); flush = 1; cycle();
        check("lit_flush_ready", seen_ready, 0);
        check("lit_flush_mask", mask16, 0);

        // Spurious writeback
        idle(); wb_valid = 1; wb_rd = 12; cycle();
        check("lit_wb_err_hi", err16, 1);
        check("lit_wb_err_mask", mask16, 0);
        idle(); cycle();
        check("lit_wb_err_lo", err16, 0);

        // Long stall saturates the narrow counter; reset mid-stall clears at once
        issue(0, 0, 4, 1); cycle();
        repeat (20) begin issue(4, 0, 0, 0); cycle(); end
        check("lit_sat15", stall4, 15);
        issue(4, 0, 0, 0);
        do_reset();

        // Randomised traffic over a small register pool to provoke hazards
        for (int k = 0; k < 3000; k++) begin
            idle();
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            issue_rd    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            issue_rd_we = ($urandom_range(0, 2) != 0);
            wb_valid    = ($urandom_range(0, 1) == 1);
            wb_rd       = 5'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 39) == 0);
            if (k == 1500) do_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_hazard_scoreboard.md
REG_HAZARD_SCOREBOARD -- requirements
Module: reg_hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural integer registers.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register index width ($clog2(NUM_REGS)).
REQ-003 SHALL have parameter STALL_CNT_W, default 16, width of the stall statistics counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port issue_valid  input  1  decoded instruction is offered for issue.
REQ-007 SHALL have port issue_rs1  input  REG_ADDR_W  source 1 index (x0 when decode forced it).
REQ-008 SHALL have port issue_rs2  input  REG_ADDR_W  source 2 index.
REQ-009 SHALL have port issue_rd  input  REG_ADDR_W  destination index.
REQ-010 SHALL have port issue_rd_we  input  1  instruction writes rd.
REQ-011 SHALL have port issue_ready  output  1  combinational; issue accepted when issue_valid & issue_ready.
REQ-012 SHALL have port wb_valid  input  1  writeback completing this cycle.
REQ-013 SHALL have port wb_rd  input  REG_ADDR_W  writeback destination index.
REQ-014 SHALL have port flush  input  1  pipeline flush; discards all in-flight writes.
REQ-015 SHALL have port pending_mask  output  NUM_REGS  registered; bit i = write to xi outstanding.
REQ-016 SHALL have port wb_err  output  1  registered one-cycle pulse: writeback to non-pending register.
REQ-017 SHALL have port stall_count  output  STALL_CNT_W  registered saturating count of stalled cycles.

Function
REQ-018 SHALL hold one pending bit per register; bit 0 (x0) SHALL be constant 0 and never set.
REQ-019 SHALL compute hazard = (pend(rs1) | pend(rs2) | (issue_rd_we & pend(rd))), where pend() indexes pending_mask and x0 never hazards.
REQ-020 SHALL drive issue_ready = !hazard & !flush, independent of issue_valid (no valid-to-ready path).
REQ-021 SHALL set pending bit rd on the edge after an accepted issue with issue_rd_we=1 and rd!=0.
REQ-022 SHALL clear pending bit wb_rd on the edge after wb_valid=1 when that bit is set.
REQ-023 SHALL, on wb_valid with wb_rd pending bit clear and wb_rd!=0, pulse wb_err high for exactly the next cycle and change no state.
REQ-024 SHALL give set priority over clear when the same cycle accepts issue to rd and writes back rd (bypass configuration only; see REQ-031).
REQ-025 SHALL, when flush=1, clear all pending bits on the next edge, ignore issue and wb_valid that cycle, and suppress wb_err.
REQ-026 SHALL increment stall_count on every cycle with issue_valid=1 and issue_ready=0, saturating at all-ones (no wrap).
REQ-027 SHALL add zero latency: issue_ready reflects pending state registered at the previous edge.
REQ-028 SHALL treat indices >= NUM_REGS as x0 (no hazard, no set, no clear).

Reset
REQ-029 SHALL, while rst_n=0, force pending_mask=0, wb_err=0, stall_count=0 asynchronously, hence issue_ready=1 unless flush.
REQ-030 SHALL resume normal operation on the first rising edge after rst_n deasserts; reset mid-operation discards all outstanding writes.

Configuration
REQ-031 SHALL support macro SCOREBOARD_WB_BYPASS_EN: when defined, a register whose writeback is presented this cycle (wb_valid & wb_rd match, no flush) is treated as not pending in REQ-019, so a dependent issue proceeds same cycle; when undefined, hazards use registered pending_mask only and dependent issue waits one extra cycle after writeback.

Verification
REQ-032 SHALL cover: reset, issue rd=5 we=1 accepted; next cycle issue rs1=5 -> issue_ready=0, stall_count=1; wb_rd=5 -> next cycle issue_ready=1, pending_mask=0.
REQ-033 SHALL cover: issue rd=0 we=1 then issue rs1=0,rs2=0 -> no stall, pending_mask stays 0.
REQ-034 SHALL cover: pending x7, issue rs2=7 with wb_valid wb_rd=7 same cycle -> issue_ready=1 with SCOREBOARD_WB_BYPASS_EN, 0 without.
REQ-035 SHALL cover: pending x3,x9, flush=1 one cycle -> pending_mask=0 next cycle, issue_ready=0 during flush.
REQ-036 SHALL cover: wb_valid wb_rd=12 with x12 not pending -> wb_err=1 exactly one cycle, pending_mask unchanged.
REQ-037 SHALL cover: STALL_CNT_W=4, hold hazard with issue_valid=1 for 20 cycles -> stall_count=15, then rst_n=0 mid-stall -> stall_count=0, pending_mask=0 immediately.
